div_sequencer: RTL and testbench

- Iterative 32-bit restoring divider with its own control FSM, sitting in the execute stage beside the ALU.
- Executes MIPS DIV/DIVU over multiple cycles and raises a one-cycle ready pulse. The hazard unit combines that pulse with the E-stage div decode to stall F/D/E until the result exists.
- Result is written to HI/LO as {remainder, quotient}.
- Aborts cleanly on an exception flush.

---
 rtl/div_sequencer_pkg.sv | 25 ++
 rtl/div_sequencer_if.sv | 23 ++
 rtl/div_iter_step.sv | 28 ++
 rtl/div_sequencer.sv | 121 ++++++++++++
 tb/tb_div_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the iterative divider.
package div_sequencer_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [WIDTH-1:0] DIV_ZERO_QUO = '1;

  typedef struct packed {
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
  } div_result_t;

  // Two's-complement negate when neg is set.
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? WIDTH'(-v) : v;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Execute-stage divide request/response bundle.
interface div_sequencer_if;
  import div_sequencer_pkg::*;

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             annul_i;
  logic             busy_o;
  logic             ready_o;
  div_result_t      result_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/div_iter_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_iter_step
  import div_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Shifted remainder needs one extra bit since it can reach 2*divisor-1.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU unit: sign-magnitude restoring divider with annul support.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  div_sequencer_if.slave  bus
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  div_result_t      result_q, result_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             a_neg, b_neg;

  assign a_neg = bus.signed_i & bus.opa_i[WIDTH-1];
  assign b_neg = bus.signed_i & bus.opb_i[WIDTH-1];

  div_iter_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      result_q <= result_d;
    end
  end

  // Result and ready are computed one cycle early so they land registered in DONE.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ready_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      DIV_IDLE: begin
        if (bus.start_i) begin
          rem_d  = '0;
          quo_d  = cond_negate(bus.opa_i, a_neg);
          dvs_d  = cond_negate(bus.opb_i, b_neg);
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (bus.opb_i == '0) begin
            state_d      = DIV_DONE;
            ready_d      = 1'b1;
            result_d.rem = bus.opa_i;
            result_d.quo = DIV_ZERO_QUO;
          end else begin
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d      = DIV_DONE;
          ready_d      = 1'b1;
          result_d.rem = cond_negate(step_rem, rneg_q);
          result_d.quo = cond_negate(step_quo, qneg_q);
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    // Flush wins over everything, including completion.
    if (bus.annul_i) begin
      state_d  = DIV_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end

    busy_d = (state_d != DIV_IDLE);
  end

  assign bus.busy_o   = busy_q;
  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized checks of div_sequencer against an arithmetic reference.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  div_sequencer_if bus ();

  div_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MIPS semantics: truncating division, {remainder, quotient}, div-by-zero convention.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a divide (caller sits at a negedge); returns at the negedge of the ready cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int exp_lat, input string tag, output logic [63:0] exp);
    int   lat;
    logic seen;
    exp          = model(a, b, sgn);
    bus.start_i  = 1'b1;
    bus.opa_i    = a;
    bus.opb_i    = b;
    bus.signed_i = sgn;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 80) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.ready_o) seen = 1'b1;
      else if (bus.busy_o) begin
        bus.opa_i    = $urandom;
        bus.opb_i    = $urandom;
        bus.signed_i = 1'($urandom);
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(bus.result_o), exp);
  endtask

  // Retire the op: ready must drop after one cycle and the result must hold.
  task automatic end_op(input string tag, input logic [63:0] exp);
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_idle"},  64'(bus.busy_o),  64'd0);
    chk({tag, "_hold"},  64'(bus.result_o), exp);
  endtask

  initial begin
    logic [63:0] exp, prev;
    logic [31:0] a, b;
    logic        sgn, in_done;

    errors       = 0;
    checks       = 0;
    resetn       = 1'b0;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.opa_i    = '0;
    bus.opb_i    = '0;
    bus.annul_i  = 1'b0;

    @(negedge clk);
    chk("rst_ready",  64'(bus.ready_o),  64'd0);
    chk("rst_busy",   64'(bus.busy_o),   64'd0);
    chk("rst_result", 64'(bus.result_o), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    do_div(32'd100, 32'd7, 1'b0, 33, "divu_100_7", exp);
    chk("divu_100_7_const", exp, {32'd2, 32'd14});
    end_op("divu_100_7", exp);

    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 33, "div_m7_2", exp);
    chk("div_m7_2_const", exp, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end_op("div_m7_2", exp);

    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 33, "div_7_m2", exp);
    end_op("div_7_m2", exp);

    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, "div_ovf", exp);
    chk("div_ovf_const", exp, {32'd0, 32'h8000_0000});
    end_op("div_ovf", exp);

    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 33, "divu_max_1", exp);
    end_op("divu_max_1", exp);

    do_div(32'h0000_1234, 32'd0, 1'b0, 1, "divu_by0", exp);
    chk("divu_by0_const", exp, {32'h0000_1234, 32'hFFFF_FFFF});
    end_op("divu_by0", exp);
    prev = exp;

    // Flush at BUSY cycle 10.
    bus.start_i  = 1'b1;
    bus.opa_i    = $urandom;
    bus.opb_i    = 32'd5;
    bus.signed_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("annul_busy_noready", 64'(bus.ready_o), 64'd0);
    end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    chk("annul_busy",   64'(bus.busy_o),   64'd0);
    chk("annul_ready",  64'(bus.ready_o),  64'd0);
    chk("annul_result", 64'(bus.result_o), prev);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("annul_quiet", 64'({bus.ready_o, bus.busy_o}), 64'd0);
    end
    do_div(32'd9, 32'd3, 1'b0, 33, "divu_9_3", exp);
    chk("divu_9_3_const", exp, {32'd0, 32'd3});
    end_op("divu_9_3", exp);
    prev = exp;

    // Flush beats a start (even a divide-by-zero one) in IDLE.
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.opa_i   = 32'd77;
    bus.opb_i   = 32'd0;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    chk("annul_idle_busy",   64'(bus.busy_o),   64'd0);
    chk("annul_idle_ready",  64'(bus.ready_o),  64'd0);
    chk("annul_idle_result", 64'(bus.result_o), prev);
    @(negedge clk);

    do_div(32'd10, 32'd3, 1'b0, 33, "b2b_first", exp);
    chk("b2b_first_const", exp, {32'd1, 32'd3});
    do_div(32'd20, 32'd6, 1'b0, 34, "b2b_second", exp);
    chk("b2b_second_const", exp, {32'd2, 32'd3});
    end_op("b2b_second", exp);

    in_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a   = $urandom;
      sgn = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      if (in_done && $urandom_range(0, 1) == 1) begin
        do_div(a, b, sgn, (b == 32'd0) ? 2 : 34, "rand_chain", exp);
      end else begin
        if (in_done) end_op("rand", exp);
        do_div(a, b, sgn, (b == 32'd0) ? 1 : 33, "rand", exp);
      end
      in_done = 1'b1;
    end
    end_op("rand_last", exp);

    // Asynchronous reset between edges while BUSY.
    do_div(32'd1000, 32'd9, 1'b0, 33, "pre_rst", exp);
    end_op("pre_rst", exp);
    bus.start_i = 1'b1;
    bus.opa_i   = 32'd12345;
    bus.opb_i   = 32'd11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_busy", 64'(bus.busy_o), 64'd1);
    bus.start_i = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_ready",  64'(bus.ready_o),  64'd0);
    chk("async_rst_busy",   64'(bus.busy_o),   64'd0);
    chk("async_rst_result", 64'(bus.result_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_busy", 64'(bus.busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
